// File: rtl/mult_sched.sv
// Two-requester 4x4 unsigned multiplier time-sharing one 2x2 multiplier over 4 cycles.
// Define RR_ARB_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mult_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_product,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy,
  output logic [1:0] dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // readies are only ever asserted in IDLE, and the result holds until res_ready is seen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic        id_q, id_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  prod_q, prod_d;
  logic        res_id_q, res_id_d;
`ifdef RR_ARB_EN
  logic        last_id_q, last_id_d;
`endif

  logic        grant_id;
  logic        accept;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic [1:0]  a_sl;
  logic [1:0]  b_sl;
  logic [3:0]  pp;
  logic [2:0]  shamt;
  logic [7:0]  pp_sh;
  logic [7:0]  acc_sum;

  always_comb begin
    if (req0_valid && req1_valid) begin
`ifdef RR_ARB_EN
      grant_id = ~last_id_q;
`else
      grant_id = 1'b0;
`endif
    end else begin
      grant_id = req1_valid;
    end
  end

  assign accept = (state_q == IDLE) && (req0_valid || req1_valid);
  assign sel_a  = grant_id ? req1_a : req0_a;
  assign sel_b  = grant_id ? req1_b : req0_b;

  // step[1] picks the a slice, step[0] the b slice; shift is 2*(i+j).
  assign a_sl    = step_q[1] ? a_q[3:2] : a_q[1:0];
  assign b_sl    = step_q[0] ? b_q[3:2] : b_q[1:0];
  assign pp      = {2'b00, a_sl} * {2'b00, b_sl};
  assign shamt   = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 1'b0};
  assign pp_sh   = {4'b0000, pp} << shamt;
  assign acc_sum = acc_q + pp_sh;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      id_q      <= 1'b0;
      acc_q     <= 8'd0;
      prod_q    <= 8'd0;
      res_id_q  <= 1'b0;
`ifdef RR_ARB_EN
      last_id_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      res_id_q  <= res_id_d;
`ifdef RR_ARB_EN
      last_id_q <= last_id_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = MUL;
      MUL:  if (step_q == 2'd3) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    res_id_d = res_id_q;
`ifdef RR_ARB_EN
    last_id_d = last_id_q;
`endif
    if (accept) begin
      a_d    = sel_a;
      b_d    = sel_b;
      id_d   = grant_id;
      acc_d  = 8'd0;
      step_d = 2'd0;
`ifdef RR_ARB_EN
      last_id_d = grant_id;
`endif
    end else if (state_q == MUL) begin
      acc_d  = acc_sum;
      step_d = step_q + 2'd1;
      if (step_q == 2'd3) begin
        prod_d   = acc_sum;
        res_id_d = id_q;
      end
    end
  end

  // Output logic.
  always_comb begin
    req0_ready  = (state_q == IDLE) && rst_n && req0_valid && !grant_id;
    req1_ready  = (state_q == IDLE) && rst_n && req1_valid && grant_id;
    res_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    res_product = prod_q;
    res_id      = res_id_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: reset, products, arbitration, back-pressure, mid-op reset.
module tb_mult_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [7:0] res_product;
  logic       res_id;
  logic       res_ready;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  mult_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_product(res_product), .res_id(res_id),
    .res_ready(res_ready), .busy(busy), .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the result handshake.
  task automatic do_op(input string tag, input logic v0, input logic v1,
                       input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1,
                       input logic exp_id, input logic [7:0] exp_prod);
    int n;
    logic [8:0] e;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = 1'b1;
    #1;
    check({tag, "_rdy0"}, req0_ready, v0 && (exp_id == 1'b0));
    check({tag, "_rdy1"}, req1_ready, v1 && (exp_id == 1'b1));
    exp_q.push_back({exp_id, exp_prod});
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a0; req0_b = ~b0; req1_a = ~a1; req1_b = ~b1;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 4);
    e = exp_q.pop_front();
    check({tag, "_prod"}, res_product, e[7:0]);
    check({tag, "_id"}, res_id, e[8]);
    @(negedge clk);
    check({tag, "_idle"}, {busy, res_valid}, 0);
    check({tag, "_hold"}, {res_id, res_product}, e);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'h1; req0_b = 4'h1; req1_a = 4'h2; req1_b = 4'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", {req0_ready, req1_ready}, 0);
    check("rst_out", {res_valid, res_id, res_product, busy}, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    do_op("ab", 1, 0, 4'hA, 4'hB, 4'h0, 4'h0, 0, 8'h6E);
    do_op("zero", 1, 0, 4'h0, 4'h9, 4'h0, 4'h0, 0, 8'h00);
    do_op("ff", 0, 1, 4'h0, 4'h0, 4'hF, 4'hF, 1, 8'hE1);

    do_op("both1", 1, 1, 4'h3, 4'h5, 4'h7, 4'h9, 0, 8'h0F);
`ifdef RR_ARB_EN
    do_op("both2", 1, 1, 4'h3, 4'h5, 4'h7, 4'h9, 1, 8'h3F);
`else
    do_op("both2", 1, 1, 4'h3, 4'h5, 4'h7, 4'h9, 0, 8'h0F);
`endif

    // Back-pressure: res_ready low while the result sits in DONE.
    req1_valid = 1'b1; req1_a = 4'h6; req1_b = 4'h7; res_ready = 1'b0;
    #1;
    check("bp_rdy1", req1_ready, 1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 0; i < 10 && !res_valid; i++) @(negedge clk);
    check("bp_valid", res_valid, 1);
    check("bp_prod", {res_id, res_product}, {1'b1, 8'h2A});
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", {res_valid, res_id, res_product, busy}, {1'b1, 1'b1, 8'h2A, 1'b1});
      check("bp_nordy", {req0_ready, req1_ready}, 0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_hs_nordy", req0_ready, 0);
    @(negedge clk);
    check("bp_idle", {busy, res_valid}, 0);
    check("bp_idle_rdy", req0_ready, 1);
    req0_valid = 1'b0;

    // Reset while step 2 of F*F is pending.
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'hF;
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mr_step2", dbg_state, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_out", {res_valid, res_id, res_product, busy}, 0);
    check("mr_state", dbg_state, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | res_valid;
    end
    check("mr_noresult", seen, 0);
    do_op("post", 1, 0, 4'h2, 4'h3, 4'h0, 4'h0, 0, 8'h06);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have no parameters; operands are fixed at 4 bits, product at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a / req0_b  input  4 each  requester 0 operands, unsigned.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  SHALL be identical to REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  result available.
REQ-009 res_product  output  8  unsigned product a*b.
REQ-010 res_id  output  1  requester that owns the result (0 or 1).
REQ-011 res_ready  input  1  consumer takes result when high with res_valid.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL compute each 4x4 product with one internal 2x2 unsigned multiplier stage, time-shared over 4 cycles; no 4x4 multiply operator.
REQ-014 FSM states SHALL be IDLE, MUL and DONE.
REQ-015 IDLE: reqN_ready SHALL be high only for the granted requester, only while its valid is high and rst_n is high; all other readies low.
REQ-016 A transfer on valid&ready SHALL latch a, b and id, clear the 8-bit accumulator, set step=0 and enter MUL.
REQ-017 MUL step k (0..3) SHALL add (a slice)*(b slice) << 2*(i+j) to the accumulator. Order: step0 a[1:0]*b[1:0], step1 a[1:0]*b[3:2], step2 a[3:2]*b[1:0], step3 a[3:2]*b[3:2].
REQ-018 After step 3 the FSM SHALL enter DONE; res_valid SHALL rise exactly 4 cycles after the accepting edge.
REQ-019 The accumulator SHALL be 8 bits and SHALL never overflow (max 15*15=225).
REQ-020 DONE: res_valid high; res_product and res_id SHALL stay stable until res_valid&res_ready, then return to IDLE.
REQ-021 No request SHALL be accepted in MUL or DONE, or in the cycle the DONE handshake completes; minimum spacing between accepts is 6 cycles.
REQ-022 res_product and res_id SHALL hold their last values after the handshake, until overwritten by the next result.
REQ-023 One requester valid in IDLE: SHALL grant that requester.
REQ-024 Both valid in IDLE: grant per REQ-030/031.
REQ-025 Input operands SHALL be ignored outside the accepting cycle.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, step=0, accumulator=0, res_product=0, res_id=0, res_valid=0, busy=0 and last_id=1; an in-flight operation is discarded without producing a result.
REQ-027 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-028 First accept SHALL be possible on the first edge after rst_n returns high.

Configuration
REQ-029 Macro RR_ARB_EN SHALL select the arbitration policy.
REQ-030 RR_ARB_EN defined: both valid -> grant the requester not equal to last_id; last_id updates to the accepted id on each accept.
REQ-031 RR_ARB_EN undefined: both valid -> requester 0 always wins; last_id is unused.

Verification
REQ-032 req0 a=4'hA, b=4'hB, res_ready=1 -> accepted, busy=1, res_valid 4 cycles later, res_product=8'h6E (110), res_id=0.
REQ-033 req1 a=4'hF, b=4'hF -> res_product=8'hE1 (225), res_id=1; req0 a=4'h0, b=4'h9 -> 8'h00.
REQ-034 Both valid for two operations (req0 3*5, req1 7*9, req0 presents 3*5 again) -> with RR_ARB_EN results 8'h0F id0 then 8'h3F id1; without it 8'h0F id0 twice while req1 stalls.
REQ-035 res_ready held low 3 cycles in DONE -> res_valid, res_product and res_id stable; both readies 0; busy=1; IDLE 1 cycle after res_ready rises.
REQ-036 rst_n low for 1 cycle during MUL step 2 of 4'hF*4'hF -> next cycle all outputs 0 and no result appears; then req0 4'h2*4'h3 -> 8'h06 after 4 cycles.
